// File: rtl/moxie_fetch_wb.sv
// Prefetching Wishbone instruction fetch for the Moxie core: halfword queue,
// variable-length instruction assembly, branch redirect, bus-error fault.
module moxie_fetch_wb #(
  parameter int                     ADDR_WIDTH   = 32,
  parameter int                     QUEUE_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = 32'h00001000,
  parameter logic [63:0]            LONG_OPS     = 64'h03C0_0015_AC00_330A
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  branch_flag_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  stall_i,
  output logic [15:0]           opcode_o,
  output logic [31:0]           operand_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  valid_o,
  output logic                  fault_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN, ST_FAULT} state_t;

  state_t                state_r;
  logic [15:0]           queue_r [QUEUE_DEPTH];
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [CW-1:0]         count_r;
  logic [ADDR_WIDTH-1:0] fetch_adr_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic                  skip_first_r;
  logic                  fault_r;

  logic [15:0]           head0_s, head1_s, head2_s;
  logic                  is_long_s, valid_s, pop_s, push_s, term_s;
  logic [CW-1:0]         pop_len_s, pop_cnt_s, push_cnt_s;
  logic [CW-1:0]         count_next_s, free_s, free_next_s;
  logic [15:0]           opcode_s;
  logic [31:0]           operand_s;

  // Head decode, flow control and queue occupancy bookkeeping
  always_comb begin
    head0_s      = queue_r[rd_ptr_r];
    head1_s      = queue_r[rd_ptr_r + PW'(1)];
    head2_s      = queue_r[rd_ptr_r + PW'(2)];
    is_long_s    = (head0_s[15:14] == 2'b00) && LONG_OPS[head0_s[13:8]];
    pop_len_s    = is_long_s ? CW'(3) : CW'(1);
    // A branch kills the head in the same cycle so decode never sees stale code
    valid_s      = !branch_flag_i && (count_r >= pop_len_s);
    pop_s        = valid_s && !stall_i;
    term_s       = wb_ack_i || wb_err_i;
    push_s       = (state_r == ST_REQ) && wb_ack_i && !branch_flag_i;
    push_cnt_s   = ZERO_C;
    if (push_s) begin
      push_cnt_s = skip_first_r ? CW'(1) : CW'(2);
    end else begin
      push_cnt_s = ZERO_C;
    end
    pop_cnt_s    = pop_s ? pop_len_s : ZERO_C;
    count_next_s = count_r + push_cnt_s - pop_cnt_s;
    free_s       = DEPTH_C - count_r;
    free_next_s  = DEPTH_C - count_next_s;
    opcode_s     = 16'h0000;
    operand_s    = 32'h0000_0000;
    if (count_r != ZERO_C) begin
      opcode_s = head0_s;
    end else begin
      opcode_s = 16'h0000;
    end
    if (is_long_s && (count_r >= CW'(3))) begin
      operand_s = {head1_s, head2_s};
    end else begin
      operand_s = 32'h0000_0000;
    end
  end

  // Fetch state machine, prefetch queue and program counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= ST_IDLE;
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= ZERO_C;
      fetch_adr_r  <= {RESET_VECTOR[ADDR_WIDTH-1:2], 2'b00};
      pc_r         <= RESET_VECTOR;
      skip_first_r <= RESET_VECTOR[1];
      fault_r      <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queue_r[i] <= 16'h0000;
      end
    end else if (branch_flag_i) begin
      wr_ptr_r     <= rd_ptr_r;
      count_r      <= ZERO_C;
      fetch_adr_r  <= {branch_target_i[ADDR_WIDTH-1:2], 2'b00};
      pc_r         <= branch_target_i;
      skip_first_r <= branch_target_i[1];
      fault_r      <= 1'b0;
      // An open cycle must still be terminated; its data will be dropped
      case (state_r)
        ST_REQ, ST_DRAIN: state_r <= term_s ? ST_IDLE : ST_DRAIN;
        default:          state_r <= ST_IDLE;
      endcase
    end else begin
      if (push_s) begin
        if (skip_first_r) begin
          queue_r[wr_ptr_r] <= wb_dat_i[15:0];
        end else begin
          queue_r[wr_ptr_r]          <= wb_dat_i[31:16];
          queue_r[wr_ptr_r + PW'(1)] <= wb_dat_i[15:0];
        end
        wr_ptr_r     <= wr_ptr_r + push_cnt_s[PW-1:0];
        skip_first_r <= 1'b0;
        fetch_adr_r  <= fetch_adr_r + ADDR_WIDTH'(4);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + pop_len_s[PW-1:0];
        pc_r     <= pc_r + (is_long_s ? ADDR_WIDTH'(6) : ADDR_WIDTH'(2));
      end
      count_r <= count_next_s;
      case (state_r)
        ST_IDLE: begin
          if ((free_s >= CW'(2)) && !fault_r) begin
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (wb_ack_i) begin
            state_r <= (free_next_s >= CW'(2)) ? ST_REQ : ST_IDLE;
          end else if (wb_err_i) begin
            fault_r <= 1'b1;
            state_r <= ST_FAULT;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_DRAIN: state_r <= term_s ? ST_IDLE : ST_DRAIN;
        ST_FAULT: state_r <= ST_FAULT;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  assign wb_cyc_o  = (state_r == ST_REQ) || (state_r == ST_DRAIN);
  assign wb_stb_o  = wb_cyc_o;
  assign wb_adr_o  = fetch_adr_r;
  assign opcode_o  = opcode_s;
  assign operand_o = operand_s;
  assign pc_o      = pc_r;
  assign valid_o   = valid_s;
  assign fault_o   = fault_r;

endmodule

// File: doc/moxie_fetch_wb.md
Name: moxie_fetch_wb

Overview:
Prefetching instruction-fetch unit for the Moxie core. It acts as a Wishbone master that reads 32-bit words into a parametrised halfword queue. It assembles variable-length Moxie instructions (16-bit opcode, plus a 32-bit operand for long forms) and presents them to decode with valid/stall flow control. It supersedes the single-word fetch path: it adds a prefetch queue, halfword-aligned branch redirection, bus-error faulting and safe abandonment of in-flight cycles.

Parameters:
ADDR_WIDTH, 32, Wishbone address and PC width
QUEUE_DEPTH, 8, queue capacity in halfwords; power of two, >= 4
RESET_VECTOR, 32'h00001000, first fetch address after reset; halfword aligned
LONG_OPS, 64'h03C0_0015_AC00_330A, bit n set = form-1 opcode n (opcode[13:8]) carries a 32-bit operand

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  asynchronous reset, active-low
wb_adr_o  out  ADDR_WIDTH  word address; bits [1:0] always 0
wb_dat_i  in  32  read data, big-endian: [31:16] = lower halfword address
wb_cyc_o  out  1  bus cycle active
wb_stb_o  out  1  strobe; always equal to wb_cyc_o
wb_ack_i  in  1  cycle acknowledge
wb_err_i  in  1  cycle error termination
branch_flag_i  in  1  redirect request from execute
branch_target_i  in  ADDR_WIDTH  redirect address; halfword aligned
stall_i  in  1  decode not accepting
opcode_o  out  16  head instruction opcode
operand_o  out  32  head operand; 0 for short instructions
pc_o  out  ADDR_WIDTH  address of opcode_o
valid_o  out  1  complete instruction at head
fault_o  out  1  bus error seen; fetching halted

Behaviour:
- Reset (rst_i=0, async) sets: state IDLE, queue empty, fetch address = RESET_VECTOR & ~3, skip_first = RESET_VECTOR[1], head pc = RESET_VECTOR. Outputs: wb_cyc_o=wb_stb_o=0, valid_o=0, fault_o=0, opcode_o=0, operand_o=0, wb_adr_o = fetch address.
- States:
  - IDLE: go to REQ when free slots >= 2 and no fault.
  - REQ: cyc=stb=1; wb_adr_o held stable until termination.
  - DRAIN: cyc=stb=1 until termination; returned data discarded.
  - FAULT: cyc=0.
- REQ, on ack: push 2 halfwords ([31:16] first), or only [15:0] if skip_first=1; clear skip_first; fetch address += 4 (wraps modulo 2^ADDR_WIDTH). Next state is REQ if free slots after the push >= 2, otherwise IDLE.
- REQ, on err: push nothing, set fault_o, go to FAULT. Queued instructions still drain normally.
- Instruction length: long iff opcode[15:14]==2'b00 and LONG_OPS[opcode[13:8]]=1. Operand = halfwords 1 and 2, first one in [31:16].
- valid_o = queue holds >= 1 halfword (short) or >= 3 (long). Outputs are combinational from the queue head, so valid_o rises the cycle after the ack edge.
- Pop occurs when valid_o && !stall_i: 1 or 3 halfwords; pc_o advances by 2 or 6. While stalled, all outputs are held stable.
- Push and pop in the same cycle: count updates by pushed minus popped.
- Never request with fewer than 2 free slots, so the queue never overflows. An empty queue yields valid_o=0, never stale data.
- Branch (branch_flag_i=1), highest priority:
  - Flush queue; valid_o is forced to 0 in the same cycle and any pop is suppressed.
  - Set fetch address = target & ~3, skip_first = target[1], pc = target, clear fault_o.
  - If a cycle is active and not terminating this cycle, go to DRAIN; otherwise go to IDLE. Any ack/err arriving in the branch cycle is discarded.
- DRAIN, on ack or err: discard, go to IDLE (err does not set fault_o).
- A branch during DRAIN re-latches the target and stays in DRAIN.
- A branch in FAULT clears the fault and goes to IDLE.
- The block never deasserts cyc/stb before ack or err.

Test Plan:
1. Reset, zero-wait slave returning 32'h0100_0000 then 32'h1234_5678 at 0x1000: first stb at 0x1000; then valid_o with opcode 0x0100 (ldi.l), operand 32'h00001234, pc 0x1000; next opcode 0x5678 at pc 0x1006.
2. stall_i held 10 cycles with a zero-wait slave: requests stop once free slots < 2 (count never exceeds 8); outputs stay stable; release pops in order.
3. Branch to 0x2002 while a 3-wait-state cycle at 0x1008 is pending: cyc held until that ack, data dropped; next request at 0x2000; first opcode = low halfword, pc 0x2002.
4. Branch in the same cycle as an ack: data discarded, no DRAIN, next cycle stb at target word.
5. wb_err_i on fetch at 0x1010: fault_o=1, cyc drops, queued instructions still pop; branch to 0x1000 clears fault and resumes fetching.
6. Fetch address 0xFFFF_FFFC with ack: next address wraps to 0x0000_0000.
